// File: rtl/fxp_sqrt_arbiter.sv
// fxp_sqrt_arbiter
// Shares one non-stallable, fixed-latency fixed-point square-root pipe between
// NREQ requesters. Operands are issued at most one per cycle under round-robin
// arbitration. Each issue is shadowed by a {valid, tag} token that travels
// alongside the sqrt pipe, and every result is captured into a first-word
// fall-through response FIFO together with its requester tag.
//
// The pipe cannot be stalled, so issue is credit-limited: an operand is only
// accepted when the operations in flight plus the results already buffered
// leave room in the FIFO. That way a result always has a slot waiting for it
// when it emerges.
//
// Optional feature: define FXP_SQRT_ARB_STATS_EN to add the 32-bit counters
// stat_issued (handshakes) and stat_stall (cycles with a request pending but
// nothing issued). Without the macro those ports do not exist.

module fxp_sqrt_arbiter #(
   parameter int NREQ  = 4,
   parameter int WII   = 10,
   parameter int WIF   = 10,
   parameter int WOI   = 6,
   parameter int WOF   = 12,
   parameter int LAT   = 20,
   parameter int DEPTH = 8
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [NREQ-1:0]                        req_valid,
   output logic [NREQ-1:0]                        req_ready,
   input  logic [NREQ*(WII+WIF)-1:0]              req_data,
   output logic [WII+WIF-1:0]                     sq_in,
   input  logic [WOI+WOF-1:0]                     sq_out,
   input  logic                                   sq_overflow,
   output logic                                   rsp_valid,
   input  logic                                   rsp_ready,
   output logic [WOI+WOF-1:0]                     rsp_data,
   output logic                                   rsp_overflow,
   output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] rsp_tag,
   output logic                                   busy
`ifdef FXP_SQRT_ARB_STATS_EN
 , output logic [31:0]                            stat_issued
 , output logic [31:0]                            stat_stall
`endif
);

   // Operand, result and tag widths.
   localparam int WIN  = WII + WIF;
   localparam int WOUT = WOI + WOF;
   localparam int TW   = (NREQ > 1) ? $clog2(NREQ) : 1;

   // Counter width must hold the value DEPTH itself, pointers only 0..DEPTH-1.
   localparam int CW   = $clog2(DEPTH + 1);
   localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // One FIFO entry: {overflow, tag, result}.
   localparam int FW   = WOUT + 1 + TW;

   // Sized copies of the parameters so comparisons stay width-matched.
   localparam logic [TW:0]   NREQ_W  = (TW+1)'(NREQ);
   localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
   localparam logic [TW-1:0] LAST_RQ = TW'(NREQ - 1);
   localparam logic [PW-1:0] LAST_PT = PW'(DEPTH - 1);

   // Arbitration state and per-requester operand view.
   logic [TW-1:0]  r_rr;
   logic [WIN-1:0] w_reqOp [NREQ];
   logic [TW-1:0]  w_grant;
   logic           w_found;
   logic           w_credit;
   logic           w_hs;

   // Tag pipe running in lock-step with the external sqrt pipe.
   logic [LAT-1:0] r_tagValid;
   logic [TW-1:0]  r_tag [LAT];
   logic           w_retire;

   // Credit counters.
   logic [CW-1:0]  r_inflight;
   logic [CW-1:0]  r_fcount;

   // Response FIFO storage and pointers.
   logic [FW-1:0]  r_mem [DEPTH];
   logic [PW-1:0]  r_wptr;
   logic [PW-1:0]  r_rptr;
   logic           w_push;
   logic           w_pop;

   // Advance a FIFO pointer, wrapping at DEPTH (DEPTH need not be a power of 2).
   function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
      return (p == LAST_PT) ? '0 : p + PW'(1);
   endfunction

   // Split the flat operand bus into one slice per requester.
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         w_reqOp[i] = req_data[i*WIN +: WIN];
      end
   end

   // Round-robin search: first valid requester starting at r_rr, wrapping.
   always_comb begin
      logic [TW:0] idx;
      idx     = '0;
      w_found = 1'b0;
      w_grant = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = {1'b0, r_rr} + (TW+1)'(k);
         if (idx >= NREQ_W) begin
            idx = idx - NREQ_W;
         end
         if (!w_found && req_valid[idx[TW-1:0]]) begin
            w_found = 1'b1;
            w_grant = idx[TW-1:0];
         end
      end
   end

   // Issue is allowed only while every outstanding result still owns a FIFO
   // slot; during reset nothing is accepted.
   always_comb begin
      w_credit  = ({1'b0, r_inflight} + {1'b0, r_fcount}) < DEPTH_W;
      w_hs      = w_found & w_credit & ~rst;
      req_ready = w_hs ? (NREQ'(1) << w_grant) : '0;
      sq_in     = w_hs ? w_reqOp[w_grant] : '0;
   end

   // Move the round-robin pointer just past the requester that was served.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr <= '0;
      end else if (w_hs) begin
         r_rr <= (w_grant == LAST_RQ) ? '0 : w_grant + TW'(1);
      end
   end

   // Shift the valid bits of the tag pipe; clearing them on reset is what
   // discards any result still travelling through the sqrt pipe.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tagValid <= '0;
      end else begin
         r_tagValid[0] <= w_hs;
         for (int s = 1; s < LAT; s++) begin
            r_tagValid[s] <= r_tagValid[s-1];
         end
      end
   end

   // Shift the requester tags; they are only meaningful where the valid bit is set.
   always_ff @(posedge clk) begin
      r_tag[0] <= w_grant;
      for (int s = 1; s < LAT; s++) begin
         r_tag[s] <= r_tag[s-1];
      end
   end

   // A valid token at the last stage means sq_out carries its result this cycle.
   always_comb begin
      w_retire  = r_tagValid[LAT-1];
      w_push    = w_retire;
      rsp_valid = ~rst & (r_fcount != '0);
      w_pop     = rsp_valid & rsp_ready;
      busy      = ~rst & ((r_inflight != '0) | (r_fcount != '0));
   end

   // Operations between issue and retire.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_inflight <= '0;
      end else begin
         r_inflight <= r_inflight + CW'(w_hs) - CW'(w_retire);
      end
   end

   // FIFO occupancy; a push and a pop in the same cycle cancel out.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fcount <= '0;
      end else begin
         r_fcount <= r_fcount + CW'(w_push) - CW'(w_pop);
      end
   end

   // FIFO pointers, each wrapping modulo DEPTH.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= nextPtr(r_wptr);
         end
         if (w_pop) begin
            r_rptr <= nextPtr(r_rptr);
         end
      end
   end

   // Capture the retiring result with its tag. The storage is not reset
   // because rsp_valid masks every stale slot.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= {sq_overflow, r_tag[LAT-1], sq_out};
      end
   end

   // First-word fall-through: the head entry is always presented.
   assign {rsp_overflow, rsp_tag, rsp_data} = r_mem[r_rptr];

`ifdef FXP_SQRT_ARB_STATS_EN
   logic r_unusedStats;
   // Count handshakes and cycles where a request waited without an issue.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_issued <= '0;
         stat_stall  <= '0;
      end else begin
         if (w_hs) begin
            stat_issued <= stat_issued + 32'd1;
         end
         if ((|req_valid) && !w_hs) begin
            stat_stall <= stat_stall + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fxp_sqrt_arbiter.sv
// Bench for fxp_sqrt_arbiter. A behavioural square-root pipe with the same
// fixed latency is attached to the DUT. A transaction-level model predicts
// every cycle: the grant from the pointer and the outstanding-operation
// count, and the response stream as an ordered queue of results, each
// becoming visible LAT+1 cycles after its issue.
// The pipe model raises its overflow flag on an odd parity of the low operand
// nibble, so that forwarding of the flag can be observed.

module tb_fxp_sqrt_arbiter;

   localparam int NREQ  = 4;
   localparam int WII   = 10;
   localparam int WIF   = 10;
   localparam int WOI   = 6;
   localparam int WOF   = 12;
   localparam int LAT   = 20;
   localparam int DEPTH = 8;
   localparam int WIN   = WII + WIF;
   localparam int WOUT  = WOI + WOF;
   localparam int TW    = 2;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ*WIN-1:0]    req_data;
   logic [WIN-1:0]         sq_in;
   logic [WOUT-1:0]        sq_out;
   logic                   sq_overflow;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [WOUT-1:0]        rsp_data;
   logic                   rsp_overflow;
   logic [TW-1:0]          rsp_tag;
   logic                   busy;
`ifdef FXP_SQRT_ARB_STATS_EN
   logic [31:0]            stat_issued;
   logic [31:0]            stat_stall;
`endif

   fxp_sqrt_arbiter #(
      .NREQ(NREQ), .WII(WII), .WIF(WIF), .WOI(WOI), .WOF(WOF), .LAT(LAT), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
      .sq_in(sq_in), .sq_out(sq_out), .sq_overflow(sq_overflow),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_overflow(rsp_overflow), .rsp_tag(rsp_tag), .busy(busy)
`ifdef FXP_SQRT_ARB_STATS_EN
    , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
   );

   always #5 clk = ~clk;

   // Rounded square root of a Q10.10 operand, returned as Q6.12.
   function automatic logic [WOUT-1:0] sqrtRef(input logic [WIN-1:0] x);
      longint n;
      longint s;
      longint t;
      n = longint'(x) << (2*WOF - WIF);
      s = 0;
      for (int b = 20; b >= 0; b--) begin
         t = s | (longint'(1) << b);
         if (t * t <= n) s = t;
      end
      if (n - s*s > s) s = s + 1;
      return WOUT'(s);
   endfunction

   function automatic logic ovfRef(input logic [WIN-1:0] x);
      return ^x[3:0];
   endfunction

   // Behavioural sqrt pipe: fixed LAT-cycle delay, synchronous active-low reset.
   logic [WOUT-1:0] pipeData [LAT];
   logic            pipeOvf  [LAT];
   logic            pipeRstn;
   assign pipeRstn    = ~rst;
   assign sq_out      = pipeData[LAT-1];
   assign sq_overflow = pipeOvf[LAT-1];

   always @(posedge clk) begin
      if (!pipeRstn) begin
         for (int s = 0; s < LAT; s++) begin
            pipeData[s] <= '0;
            pipeOvf[s]  <= 1'b0;
         end
      end else begin
         pipeData[0] <= sqrtRef(sq_in);
         pipeOvf[0]  <= ovfRef(sq_in);
         for (int s = 1; s < LAT; s++) begin
            pipeData[s] <= pipeData[s-1];
            pipeOvf[s]  <= pipeOvf[s-1];
         end
      end
   end

   typedef struct {
      int              tag;
      logic [WOUT-1:0] data;
      logic            ovf;
      int              readyCyc;
   } rsp_t;

   rsp_t expQ[$];
   int   rrM;
   int   cur;
   int   hsCount;
   int   stallCount;
   int   hsTotal;
   int   grantCount [NREQ];

   int   checkCount;
   int   passCount;
   int   failCount;

   logic            lastRspValid;
   logic [WOUT-1:0] lastRspData;
   logic [TW-1:0]   lastRspTag;
   logic            lastRspOvf;
   logic            lastBusy;

   task automatic checkOutput(input string tag, input longint observed, input longint expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         failCount++;
         $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", tag, observed, expected, cur);
      end
   endtask

   // Drive one cycle of inputs, check every output against the model, then
   // advance the model across the clock edge.
   task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [NREQ*WIN-1:0] d,
                                input logic rdy, input logic r);
      int   g;
      int   idx;
      int   expF;
      bit   hs;
      bit   expRV;
      bit   pop;
      logic [NREQ-1:0] expReady;
      logic [WIN-1:0]  expSqIn;

      req_valid = v;
      req_data  = d;
      rsp_ready = rdy;
      rst       = r;
      #1;

      g = -1;
      if (!r) begin
         for (int k = 0; k < NREQ; k++) begin
            idx = (rrM + k) % NREQ;
            if (g < 0 && v[idx]) g = idx;
         end
      end
      hs       = !r && (g >= 0) && (expQ.size() < DEPTH);
      expReady = hs ? NREQ'(1) << g : '0;
      expSqIn  = hs ? d[g*WIN +: WIN] : '0;
      expRV    = !r && (expQ.size() > 0) && (expQ[0].readyCyc <= cur);
      expF     = 0;
      foreach (expQ[i]) if (expQ[i].readyCyc <= cur) expF++;

      checkOutput("req_ready", longint'(req_ready), longint'(expReady));
      checkOutput("sq_in",     longint'(sq_in),     longint'(expSqIn));
      checkOutput("rsp_valid", longint'(rsp_valid), longint'(expRV));
      checkOutput("busy",      longint'(busy),      longint'(!r && expQ.size() > 0));
      checkOutput("fcount",    longint'(dut.r_fcount), longint'(expF));
      if (expRV) begin
         checkOutput("rsp_data", longint'(rsp_data),     longint'(expQ[0].data));
         checkOutput("rsp_tag",  longint'(rsp_tag),      longint'(expQ[0].tag));
         checkOutput("rsp_ovf",  longint'(rsp_overflow), longint'(expQ[0].ovf));
      end
      if (!r && dut.r_tagValid[LAT-1]) begin
         checkOutput("pushIntoFull",
                     longint'(int'(dut.r_fcount) == DEPTH && !(rsp_valid && rsp_ready)), 0);
      end

      lastRspValid = rsp_valid;
      lastRspData  = rsp_data;
      lastRspTag   = rsp_tag;
      lastRspOvf   = rsp_overflow;
      lastBusy     = busy;
      pop          = expRV && rdy;

      @(posedge clk);
      if (r) begin
         expQ.delete();
         rrM        = 0;
         hsCount    = 0;
         stallCount = 0;
      end else begin
         if (pop) void'(expQ.pop_front());
         if (hs) begin
            expQ.push_back('{tag: g, data: sqrtRef(d[g*WIN +: WIN]),
                             ovf: ovfRef(d[g*WIN +: WIN]), readyCyc: cur + LAT + 1});
            rrM = (g + 1) % NREQ;
            hsCount++;
            hsTotal++;
            grantCount[g]++;
         end else if (v != '0) begin
            stallCount++;
         end
      end
      cur++;
      @(negedge clk);
   endtask

   function automatic logic [NREQ*WIN-1:0] randOps();
      logic [NREQ*WIN-1:0] d;
      for (int i = 0; i < NREQ; i++) d[i*WIN +: WIN] = WIN'($urandom);
      return d;
   endfunction

   initial begin
      logic [NREQ*WIN-1:0] d;
      int base;
      int riseAt;
      int stale;
      int gMin;
      int gMax;
      int nSeen;
      logic [WOUT-1:0] seenData [2];
      logic [TW-1:0]   seenTag  [2];
      logic            seenOvf  [2];

      checkCount = 0; passCount = 0; failCount = 0;
      cur = 0; rrM = 0; hsCount = 0; stallCount = 0; hsTotal = 0;
      for (int i = 0; i < NREQ; i++) grantCount[i] = 0;
      rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b0;
      @(negedge clk);

      // Reset state.
      applyStimulus('0, '0, 1'b0, 1'b1);
      applyStimulus('0, '0, 1'b0, 1'b1);
      checkOutput("resetRr", longint'(dut.r_rr), 0);

      // Single request from requester 2: 64.0 -> 8.0 after LAT+1 cycles.
      d = '0;
      d[2*WIN +: WIN] = WIN'('h10000);
      applyStimulus(4'b0100, d, 1'b1, 1'b0);
      riseAt = -1;
      for (int n = 1; n <= LAT + 4; n++) begin
         applyStimulus('0, d, 1'b1, 1'b0);
         if (lastRspValid && riseAt < 0) begin
            riseAt = n;
            checkOutput("singleData", longint'(lastRspData), 'h08000);
            checkOutput("singleTag",  longint'(lastRspTag), 2);
            checkOutput("singleOvf",  longint'(lastRspOvf), 0);
         end
         if (n == LAT + 2) checkOutput("singleBusyFall", longint'(lastBusy), 0);
      end
      checkOutput("singleLatency", riseAt, LAT + 1);

      // Fairness with all requesters active and the consumer always ready.
      for (int i = 0; i < NREQ; i++) grantCount[i] = 0;
      for (int n = 0; n < 400; n++) applyStimulus('1, randOps(), 1'b1, 1'b0);
      gMin = grantCount[0]; gMax = grantCount[0];
      for (int i = 1; i < NREQ; i++) begin
         if (grantCount[i] < gMin) gMin = grantCount[i];
         if (grantCount[i] > gMax) gMax = grantCount[i];
      end
      checkOutput("fairSpread", longint'(gMax - gMin <= 1), 1);
      checkOutput("fairActive", longint'(gMin > 0), 1);
      for (int n = 0; n < LAT + 12; n++) applyStimulus('0, '0, 1'b1, 1'b0);

      // Backpressure: exactly DEPTH issues, then one more per single pop.
      base = hsTotal;
      for (int n = 0; n < 40; n++) applyStimulus('1, randOps(), 1'b0, 1'b0);
      checkOutput("bpIssued", hsTotal - base, DEPTH);
      applyStimulus('1, randOps(), 1'b1, 1'b0);
      for (int n = 0; n < 30; n++) applyStimulus('1, randOps(), 1'b0, 1'b0);
      checkOutput("bpOneMore", hsTotal - base, DEPTH + 1);
      checkOutput("bpFull", longint'(dut.r_fcount), DEPTH);

      // From a full FIFO: one requester held while draining.
      for (int n = 0; n < 60; n++) applyStimulus(4'b0010, randOps(), 1'b1, 1'b0);
      for (int n = 0; n < LAT + 12; n++) applyStimulus('0, '0, 1'b1, 1'b0);

      // Reset with 3 results buffered and 5 operations in flight.
      for (int n = 0; n < 3; n++) applyStimulus(4'b0001, randOps(), 1'b0, 1'b0);
      for (int n = 0; n < LAT + 1; n++) applyStimulus('0, '0, 1'b0, 1'b0);
      for (int n = 0; n < 5; n++) applyStimulus(4'b1000, randOps(), 1'b0, 1'b0);
      applyStimulus('0, '0, 1'b0, 1'b0);
      checkOutput("preResetFcount", longint'(dut.r_fcount), 3);
      applyStimulus('0, '0, 1'b1, 1'b1);
      checkOutput("postResetRr", longint'(dut.r_rr), 0);
      stale = 0;
      for (int n = 0; n < LAT + 2; n++) begin
         applyStimulus('0, '0, 1'b1, 1'b0);
         if (n == 0) begin
            checkOutput("postResetValid", longint'(lastRspValid), 0);
            checkOutput("postResetBusy",  longint'(lastBusy), 0);
         end
         if (lastRspValid) stale++;
      end
      checkOutput("noStaleResult", stale, 0);

      // Zero operand and overflow forwarding.
      d = '0;
      d[3*WIN +: WIN] = WIN'('h00401);
      applyStimulus(4'b1001, d, 1'b1, 1'b0);
      applyStimulus(4'b1001, d, 1'b1, 1'b0);
      nSeen = 0;
      for (int n = 0; n < LAT + 6; n++) begin
         applyStimulus('0, d, 1'b1, 1'b0);
         if (lastRspValid && nSeen < 2) begin
            seenData[nSeen] = lastRspData;
            seenTag[nSeen]  = lastRspTag;
            seenOvf[nSeen]  = lastRspOvf;
            nSeen++;
         end
      end
      checkOutput("ovfCount",    nSeen, 2);
      checkOutput("zeroData",    longint'(seenData[0]), 0);
      checkOutput("zeroTag",     longint'(seenTag[0]), 0);
      checkOutput("ovfTag",      longint'(seenTag[1]), 3);
      checkOutput("ovfForward",  longint'(seenOvf[1]), 1);
      checkOutput("ovfData",     longint'(seenData[1]), longint'(sqrtRef(WIN'('h00401))));

      // Random traffic with occasional consumer stalls and resets.
      for (int n = 0; n < 600; n++) begin
         applyStimulus(NREQ'($urandom), randOps(), ($urandom_range(0, 9) < 7),
                       ($urandom_range(0, 199) == 0));
      end

`ifdef FXP_SQRT_ARB_STATS_EN
      checkOutput("statIssued", longint'(stat_issued), hsCount);
      checkOutput("statStall",  longint'(stat_stall),  stallCount);
`endif

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
